// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and rising-to-rising period of pwm_in in
// clk_in cycles, strobes valid per complete period, flags loss of signal.
module pwm_capture #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             s1, s2, d;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] hi_lat, hi_lat_nxt;
  logic [CNT_W-1:0] high_time_nxt, period_nxt;
  logic             valid_nxt, timeout_nxt;

  // Both edges pass through the same s1/s2/d chain, so their delays cancel.
  always_ff @(negedge clk_in or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d  <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      d  <= s2;
    end
  end

  assign rise    = s2 & ~d;
  assign fall    = ~s2 & d;
  assign cnt_inc = (cnt == TO_VAL) ? cnt : cnt + ONE;

  always_ff @(negedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_lat    <= '0;
      high_time <= '0;
      period    <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hi_lat    <= hi_lat_nxt;
      high_time <= high_time_nxt;
      period    <= period_nxt;
      valid     <= valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

  // Edges are tested before the timeout condition so an edge always wins.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hi_lat_nxt    = hi_lat;
    high_time_nxt = high_time;
    period_nxt    = period;
    valid_nxt     = 1'b0;
    timeout_nxt   = timeout;
    unique case (state)
      IDLE: begin
        if (rise) begin
          cnt_nxt   = ONE;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          hi_lat_nxt = cnt;
          cnt_nxt    = cnt_inc;
          state_nxt  = LOW;
        end else if (cnt == TO_VAL) begin
          timeout_nxt = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      LOW: begin
        if (rise) begin
          period_nxt    = cnt;
          high_time_nxt = hi_lat;
          valid_nxt     = 1'b1;
          timeout_nxt   = 1'b0;
          cnt_nxt       = ONE;
          state_nxt     = HIGH;
        end else if (cnt == TO_VAL) begin
          timeout_nxt = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus queues the expected report for
// each completed period; a monitor pops and compares on every valid strobe.
module tb_pwm_capture;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TO    = 200;

  logic             clk_in = 1'b0;
  logic             rst    = 1'b1;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             timeout;

  typedef struct {
    int unsigned ht;
    int unsigned per;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  bit          have_prev = 0;
  int unsigned prev_hi  = 0;
  int unsigned prev_per = 0;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .pwm_in   (pwm_in),
    .high_time(high_time),
    .period   (period),
    .valid    (valid),
    .timeout  (timeout)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs change on the falling edge; sample on the rising edge.
  always @(posedge clk_in) begin
    if (!rst && valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("high_time", high_time, e.ht);
        check("period", period, e.per);
        check("timeout_at_valid", timeout, 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
  endtask

  task automatic push_prev();
    exp_t e;
    if (have_prev) begin
      e.ht  = prev_hi;
      e.per = prev_per;
      q.push_back(e);
    end
  endtask

  task automatic drive_period(input int unsigned hi, input int unsigned per);
    push_prev();
    have_prev = 1;
    prev_hi   = hi;
    prev_per  = per;
    pwm_in = 1'b1;
    tick(int'(hi));
    pwm_in = 1'b0;
    tick(int'(per - hi));
  endtask

  initial begin
    tick(3);
    check("rst_high_time", high_time, 0);
    check("rst_period", period, 0);
    check("rst_valid", valid, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0;
    tick(2);

    // 40/100 steady, first period discarded
    repeat (4) drive_period(40, 100);
    // duty steps 80 then 10
    drive_period(80, 100);
    drive_period(10, 100);

    // one more rise closes the 10/100 period, then the line goes quiet low
    push_prev();
    have_prev = 0;
    pwm_in = 1'b1;
    tick(50);
    pwm_in = 1'b0;
    tick(150);
    check("low_timeout_early", timeout, 0);
    tick(6);
    check("low_timeout_set", timeout, 1);
    check("low_hold_high_time", high_time, 10);
    check("low_hold_period", period, 100);

    // resume 30/100, first period discarded
    repeat (3) drive_period(30, 100);
    check("resume_timeout_clr", timeout, 0);

    // stuck high
    push_prev();
    have_prev = 0;
    pwm_in = 1'b1;
    tick(210);
    check("high_timeout_set", timeout, 1);
    check("high_hold_high_time", high_time, 30);
    check("high_hold_period", period, 100);
    pwm_in = 1'b0;
    tick(5);
    repeat (3) drive_period(20, 50);

    // minimum 1/2 pulses
    repeat (10) drive_period(1, 2);

    // reset mid-HIGH
    push_prev();
    have_prev = 0;
    pwm_in = 1'b1;
    tick(20);
    rst = 1'b1;
    #1;
    check("midrst_high_time", high_time, 0);
    check("midrst_period", period, 0);
    check("midrst_valid", valid, 0);
    check("midrst_timeout", timeout, 0);
    pwm_in = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(3);
    repeat (3) drive_period(40, 100);

    tick(20);
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
